// File: rtl/uart_receiver.sv
// UART receive path: 2-flop rxd synchronizer, oversampled start/data/stop FSM,
// and a single-entry holding register with ready, framing-error and overrun flags.
module uart_receiver #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_r_enable,
  input  logic                 rxd,
  input  logic                 data_r_enable,
  output logic [DATA_BITS-1:0] data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          tick_reg, tick_next;
  logic [BW-1:0]          bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   rxd_meta, rxd_s;
  logic                   frame_done;

  // rxd is asynchronous to clk; only rxd_s may reach the FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_IDLE;
      tick_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    tick_next  = tick_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    frame_done = 1'b0;
    if (baud_r_enable) begin
      case (state_reg)
        S_IDLE: begin
          if (!rxd_s) begin
            state_next = S_START;
            tick_next  = '0;
          end
        end
        S_START: begin
          if (tick_reg == HALF_M1) begin
            tick_next = '0;
            if (!rxd_s) begin
              state_next = S_DATA;
              bit_next   = '0;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
        S_DATA: begin
          // Sampling one full bit period after the start-bit centre lands on each bit centre.
          if (tick_reg == FULL_M1) begin
            tick_next  = '0;
            shift_next = {rxd_s, shift_reg[DATA_BITS-1:1]};
            bit_next   = bit_reg + BW'(1);
            if (bit_reg == LAST_BIT) state_next = S_STOP;
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
        S_STOP: begin
          if (tick_reg == FULL_M1) begin
            tick_next  = '0;
            frame_done = 1'b1;
            state_next = rxd_s ? S_IDLE : S_BRK;
          end else begin
            tick_next = tick_reg + TW'(1);
          end
        end
        S_BRK: begin
          if (rxd_s) state_next = S_IDLE;
        end
        default: state_next = S_IDLE;
      endcase
    end
  end

  // A read in the completion cycle frees the holding register for the new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data      <= '0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else if (frame_done) begin
      if (!rda || data_r_enable) begin
        data      <= shift_reg;
        rda       <= 1'b1;
        frame_err <= ~rxd_s;
        overrun   <= 1'b0;
      end else begin
        overrun <= 1'b1;
      end
    end else if (data_r_enable && rda) begin
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: a behavioural transmitter drives rxd,
// each scenario task checks the receiver outputs against hand-computed values.
module tb_uart_receiver;
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       baud_r_enable = 1'b1;
  logic       rxd = 1'b1;
  logic       data_r_enable = 1'b0;
  logic [7:0] data;
  logic       rda;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic rda_prev = 1'b0;
  bit rand_ticks = 1'b0;

  uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk(clk),
    .rst(rst),
    .baud_r_enable(baud_r_enable),
    .rxd(rxd),
    .data_r_enable(data_r_enable),
    .data(data),
    .rda(rda),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rda && !rda_prev) rise_cyc <= cyc;
    rda_prev <= rda;
  end

  initial begin
    forever begin
      @(negedge clk);
      baud_r_enable = rand_ticks ? ($urandom_range(7) != 0) : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_r_enable) k++;
    end
    #1;
  endtask

  // Transmitter model: start, 8 data bits LSB first, stop; each bit is OS ticks long.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    wait_ticks(1);
    start_cyc = cyc;
    rxd = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_ticks(OS);
    end
    rxd = stop_bit;
    wait_ticks(OS);
  endtask

  task automatic read_byte();
    @(negedge clk);
    data_r_enable = 1'b1;
    @(negedge clk);
    data_r_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL reset_rda got %b want 0", rda); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got %b want 0", overrun); end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'hC3, 1'b1);
    @(negedge clk);
    checks++; if (rda !== 1'b1 || data !== 8'hC3) begin errors++; $display("FAIL pre_reset_frame got rda=%b data=%h want 1 c3", rda, data); end
    wait_ticks(1);
    rxd = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL midframe_reset_data got %h want 00", data); end
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL midframe_reset_rda got %b want 0", rda); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL midframe_reset_ferr got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL midframe_reset_ovr got %b want 0", overrun); end
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL post_reset_rda got %b want 0", rda); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL post_reset_data got %h want 00", data); end
    $display("test_reset done rda=%b data=%h", rda, data);
  endtask

  task automatic test_nominal();
    int lat;
    send_frame(8'hA5, 1'b1);
    @(negedge clk);
    lat = rise_cyc - start_cyc;
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL nominal_data got %h want a5", data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL nominal_rda got %b want 1", rda); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL nominal_ferr got %b want 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL nominal_ovr got %b want 0", overrun); end
    checks++; if (lat < 9 * OS + OS / 2 || lat > 10 * OS) begin errors++; $display("FAIL nominal_latency got %0d want %0d..%0d", lat, 9 * OS + OS / 2, 10 * OS); end
    read_byte();
    checks++; if (rda !== 1'b0 || data !== 8'hA5) begin errors++; $display("FAIL nominal_read got rda=%b data=%h want 0 a5", rda, data); end
    $display("test_nominal data=%h latency=%0d", data, lat);
  endtask

  task automatic test_glitch();
    wait_ticks(1);
    rxd = 1'b0;
    wait_ticks(4);
    rxd = 1'b1;
    repeat (50) @(negedge clk);
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL glitch_rda got %b want 0", rda); end
    send_frame(8'h3C, 1'b1);
    @(negedge clk);
    checks++; if (rda !== 1'b1 || data !== 8'h3C) begin errors++; $display("FAIL glitch_next_frame got rda=%b data=%h want 1 3c", rda, data); end
    read_byte();
    $display("test_glitch data=%h", data);
  endtask

  task automatic test_framing();
    send_frame(8'h55, 1'b0);
    wait_ticks(12 * OS);
    @(negedge clk);
    checks++; if (data !== 8'h55) begin errors++; $display("FAIL framing_data got %h want 55", data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL framing_rda got %b want 1", rda); end
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL framing_ferr got %b want 1", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL framing_break_ovr got %b want 0", overrun); end
    rxd = 1'b1;
    repeat (10) @(negedge clk);
    read_byte();
    checks++; if (rda !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL framing_read got rda=%b ferr=%b want 0 0", rda, frame_err); end
    $display("test_framing data=%h", data);
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    @(negedge clk);
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL overrun_data got %h want 11", data); end
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL overrun_rda got %b want 1", rda); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL overrun_ferr got %b want 0", frame_err); end
    read_byte();
    checks++; if (rda !== 1'b0) begin errors++; $display("FAIL overrun_read_rda got %b want 0", rda); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_read_ovr got %b want 0", overrun); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL overrun_read_ferr got %b want 0", frame_err); end
    checks++; if (data !== 8'h11) begin errors++; $display("FAIL overrun_read_data got %h want 11", data); end
    $display("test_overrun data=%h", data);
  endtask

  // With a tick every clk the stop-bit centre completes on the 156th edge counted from
  // the start edge, so the read strobe is placed in the cycle ending at that edge.
  task automatic test_race();
    send_frame(8'h01, 1'b1);
    @(negedge clk);
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL race_setup_rda got %b want 1", rda); end
    fork
      send_frame(8'h7E, 1'b1);
      begin
        repeat (10 * OS - 5) @(posedge clk);
        @(negedge clk);
        data_r_enable = 1'b1;
        @(negedge clk);
        data_r_enable = 1'b0;
      end
    join
    @(negedge clk);
    checks++; if (rda !== 1'b1) begin errors++; $display("FAIL race_rda got %b want 1", rda); end
    checks++; if (data !== 8'h7E) begin errors++; $display("FAIL race_data got %h want 7e", data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL race_ovr got %b want 0", overrun); end
    read_byte();
    $display("test_race data=%h", data);
  endtask

  task automatic test_loopback();
    logic [7:0] b;
    int bad;
    bad = 0;
    rand_ticks = 1'b1;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1);
      @(negedge clk);
      checks++;
      if (rda !== 1'b1 || data !== b || frame_err !== 1'b0 || overrun !== 1'b0) begin
        errors++;
        bad++;
        $display("FAIL loopback_%0d got rda=%b data=%h ferr=%b ovr=%b want 1 %h 0 0", i, rda, data, frame_err, overrun, b);
      end
      read_byte();
    end
    rand_ticks = 1'b0;
    $display("test_loopback bytes=256 bad=%0d", bad);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_framing();
    test_overrun();
    test_race();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
